// File: rtl/gpio_irq_pkg.sv
// GPIO interrupt controller shared definitions:
// register offsets, CONFIG field positions and MSI FSM encoding.
package gpio_irq_pkg;

    localparam logic [2:0] REG_DATA_IN  = 3'd0;
    localparam logic [2:0] REG_DATA_OUT = 3'd1;
    localparam logic [2:0] REG_DIR      = 3'd2;
    localparam logic [2:0] REG_MASK     = 3'd3;
    localparam logic [2:0] REG_RISE     = 3'd4;
    localparam logic [2:0] REG_FALL     = 3'd5;
    localparam logic [2:0] REG_STATUS   = 3'd6;
    localparam logic [2:0] REG_CONFIG   = 3'd7;

    localparam int CFG_GIE_BIT  = 0;
    localparam int CFG_HOLD_LSB = 16;

    typedef enum logic [1:0] {
        MSI_IDLE = 2'd0,
        MSI_REQ  = 2'd1,
        MSI_HOLD = 2'd2
    } msi_state_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-stage pad synchroniser with rise/fall detection
// on the synchronised value against its one-cycle-older copy.
module gpio_sync_edge #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         trn_reset_n,
    input  logic [N-1:0] gpio_in,
    output logic [N-1:0] sync_out,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);

    logic [N-1:0] sync_q [STAGES];
    logic [N-1:0] prev_q;

    always_ff @(posedge clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_out = sync_q[STAGES-1];
    assign rise     = sync_q[STAGES-1] & ~prev_q;
    assign fall     = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO bank with edge-captured sticky status and
// rate-limited MSI request generation.
module gpio_irq_ctrl
    import gpio_irq_pkg::*;
#(
    parameter int N_GPIO      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_W      = 16
) (
    input  logic              clk,
    input  logic              trn_reset_n,
    input  logic              reg_wr,
    input  logic              reg_rd,
    input  logic [2:0]        reg_addr,
    input  logic [31:0]       reg_wdata,
    output logic [31:0]       reg_rdata,
    output logic              reg_rvalid,
    input  logic [N_GPIO-1:0] gpio_in,
    output logic [N_GPIO-1:0] gpio_out,
    output logic [N_GPIO-1:0] gpio_oe,
    input  logic              cfg_interrupt_msienable,
    output logic              cfg_interrupt_n,
    input  logic              cfg_interrupt_rdy_n,
    output logic              irq_pending
);

    logic [N_GPIO-1:0] sync_in, rise, fall, evt;
    logic [N_GPIO-1:0] data_out_q, dir_q, mask_q;
    logic [N_GPIO-1:0] rise_q, fall_q, status_q;
    logic [N_GPIO-1:0] status_d, w1c;
    logic              gie_q;
    logic [HOLD_W-1:0] holdoff_q, cnt_q, cnt_d;
    logic              arm_q, arm_d, accept;
    logic              rd_q;
    logic [31:0]       rd_data_q, rd_mux;
    msi_state_e        state_q, state_d;
    logic              wdata_unused;

    gpio_sync_edge #(
        .N      (N_GPIO),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .trn_reset_n (trn_reset_n),
        .gpio_in     (gpio_in),
        .sync_out    (sync_in),
        .rise        (rise),
        .fall        (fall)
    );

    assign wdata_unused = ^reg_wdata;

    assign evt = (rise_q & rise) | (fall_q & fall);
    assign w1c = (reg_wr && reg_addr == REG_STATUS)
               ? reg_wdata[N_GPIO-1:0] : '0;
    // A capture in the same cycle as a W1C wins.
    assign status_d = (status_q & ~w1c) | evt;
    assign arm_d = (arm_q & ~accept) | (|(evt & mask_q));

    always_ff @(posedge clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            data_out_q <= '0;
            dir_q      <= '0;
            mask_q     <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            status_q   <= '0;
            gie_q      <= 1'b0;
            holdoff_q  <= '0;
            arm_q      <= 1'b0;
        end else begin
            status_q <= status_d;
            arm_q    <= arm_d;
            if (reg_wr) begin
                case (reg_addr)
                    REG_DATA_OUT: data_out_q <= reg_wdata[N_GPIO-1:0];
                    REG_DIR:      dir_q      <= reg_wdata[N_GPIO-1:0];
                    REG_MASK:     mask_q     <= reg_wdata[N_GPIO-1:0];
                    REG_RISE:     rise_q     <= reg_wdata[N_GPIO-1:0];
                    REG_FALL:     fall_q     <= reg_wdata[N_GPIO-1:0];
                    REG_CONFIG: begin
                        gie_q     <= reg_wdata[CFG_GIE_BIT];
                        holdoff_q <= reg_wdata[CFG_HOLD_LSB +: HOLD_W];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            REG_DATA_IN:  rd_mux[N_GPIO-1:0] = sync_in;
            REG_DATA_OUT: rd_mux[N_GPIO-1:0] = data_out_q;
            REG_DIR:      rd_mux[N_GPIO-1:0] = dir_q;
            REG_MASK:     rd_mux[N_GPIO-1:0] = mask_q;
            REG_RISE:     rd_mux[N_GPIO-1:0] = rise_q;
            REG_FALL:     rd_mux[N_GPIO-1:0] = fall_q;
            REG_STATUS:   rd_mux[N_GPIO-1:0] = status_q;
            REG_CONFIG: begin
                rd_mux[CFG_GIE_BIT]            = gie_q;
                rd_mux[CFG_HOLD_LSB +: HOLD_W] = holdoff_q;
            end
        endcase
    end

    // Two-stage read path: sample in T, present in T+2.
    always_ff @(posedge clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            rd_q       <= 1'b0;
            rd_data_q  <= '0;
            reg_rvalid <= 1'b0;
            reg_rdata  <= '0;
        end else begin
            rd_q       <= reg_rd;
            reg_rvalid <= rd_q;
            if (reg_rd) rd_data_q <= rd_mux;
            if (rd_q)   reg_rdata <= rd_data_q;
        end
    end

    always_ff @(posedge clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            state_q <= MSI_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            MSI_IDLE: begin
                if (arm_q && gie_q && cfg_interrupt_msienable)
                    state_d = MSI_REQ;
            end
            MSI_REQ: begin
                if (!cfg_interrupt_rdy_n) begin
                    accept  = 1'b1;
                    state_d = MSI_HOLD;
                    cnt_d   = holdoff_q;
                end else if (!gie_q || !cfg_interrupt_msienable) begin
                    state_d = MSI_IDLE;
                end
            end
            MSI_HOLD: begin
                if (cnt_q == '0) state_d = MSI_IDLE;
                else             cnt_d   = cnt_q - HOLD_W'(1);
            end
            default: state_d = MSI_IDLE;
        endcase
    end

    assign cfg_interrupt_n = (state_q != MSI_REQ);
    assign irq_pending     = |(status_q & mask_q);
    assign gpio_out        = data_out_q;
    assign gpio_oe         = dir_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Scoreboard bench for gpio_irq_ctrl: directed scenarios
// followed by randomized traffic against a behavioural model.
module tb_gpio_irq_ctrl;

    localparam int N  = 8;
    localparam int S  = 2;
    localparam int HW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          reg_wr = 1'b0;
    logic          reg_rd = 1'b0;
    logic [2:0]    reg_addr = '0;
    logic [31:0]   reg_wdata = '0;
    logic [31:0]   reg_rdata;
    logic          reg_rvalid;
    logic [N-1:0]  gpio_in = '0;
    logic [N-1:0]  gpio_out, gpio_oe;
    logic          msien = 1'b0;
    logic          cfg_interrupt_n;
    logic          rdy_n = 1'b1;
    logic          irq_pending;

    logic          auto_ack = 1'b0;
    logic          force_ack = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    gpio_irq_ctrl #(.N_GPIO(N), .SYNC_STAGES(S), .HOLD_W(HW)) dut (
        .clk                     (clk),
        .trn_reset_n             (rst_n),
        .reg_wr                  (reg_wr),
        .reg_rd                  (reg_rd),
        .reg_addr                (reg_addr),
        .reg_wdata               (reg_wdata),
        .reg_rdata               (reg_rdata),
        .reg_rvalid              (reg_rvalid),
        .gpio_in                 (gpio_in),
        .gpio_out                (gpio_out),
        .gpio_oe                 (gpio_oe),
        .cfg_interrupt_msienable (msien),
        .cfg_interrupt_n         (cfg_interrupt_n),
        .cfg_interrupt_rdy_n     (rdy_n),
        .irq_pending             (irq_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct { int due; logic [31:0] data; } rd_t;
    rd_t          rdq[$];
    logic [N-1:0] pad_hist[$];
    logic [N-1:0] m_dout = '0, m_dir = '0, m_mask = '0;
    logic [N-1:0] m_rise = '0, m_fall = '0, m_stat = '0;
    logic         m_gie = 1'b0;
    logic [HW-1:0] m_hold = '0;
    logic         m_arm = 1'b0, m_req = 1'b0;
    int           m_holdcnt = -1;
    logic [31:0]  m_last = '0;
    logic [N-1:0] cur, prev, ev, w1c;
    logic         acc;

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return 32'(pad_hist[S-1]);
            3'd1: return 32'(m_dout);
            3'd2: return 32'(m_dir);
            3'd3: return 32'(m_mask);
            3'd4: return 32'(m_rise);
            3'd5: return 32'(m_fall);
            3'd6: return 32'(m_stat);
            default: return {m_hold, 15'd0, m_gie};
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dout = '0; m_dir = '0; m_mask = '0;
            m_rise = '0; m_fall = '0; m_stat = '0;
            m_gie = 1'b0; m_hold = '0;
            m_arm = 1'b0; m_req = 1'b0; m_holdcnt = -1;
            m_last = '0;
            rdq.delete();
            pad_hist.delete();
            repeat (S + 1) pad_hist.push_back('0);
        end else begin
            cyc++;
            cur  = pad_hist[S-1];
            prev = pad_hist[S];
            ev   = (m_rise & cur & ~prev) | (m_fall & ~cur & prev);
            if (reg_rd) rdq.push_back('{cyc + 1, m_read(reg_addr)});
            acc = m_req && !rdy_n;
            m_arm = (m_arm && !acc) || ((ev & m_mask) != '0);
            // request lifecycle: idle -> request -> holdoff+1 quiet cycles
            if (m_holdcnt >= 0) begin
                if (m_holdcnt == 0) m_holdcnt = -1;
                else m_holdcnt--;
            end else if (m_req) begin
                if (acc) begin
                    m_req = 1'b0;
                    m_holdcnt = int'(m_hold);
                end else if (!(m_gie && msien)) begin
                    m_req = 1'b0;
                end
            end else if (m_arm_q_for_req()) begin
                m_req = 1'b1;
            end
            w1c = '0;
            if (reg_wr) begin
                case (reg_addr)
                    3'd1: m_dout = reg_wdata[N-1:0];
                    3'd2: m_dir  = reg_wdata[N-1:0];
                    3'd3: m_mask = reg_wdata[N-1:0];
                    3'd4: m_rise = reg_wdata[N-1:0];
                    3'd5: m_fall = reg_wdata[N-1:0];
                    3'd6: w1c    = reg_wdata[N-1:0];
                    3'd7: begin
                        m_gie  = reg_wdata[0];
                        m_hold = reg_wdata[31:16];
                    end
                    default: ;
                endcase
            end
            m_stat = (m_stat & ~w1c) | ev;
            pad_hist.push_front(gpio_in);
            void'(pad_hist.pop_back());
        end
    end

    // Arm as it stood before this edge's events; captured before update.
    logic m_arm_prev = 1'b0;
    always @(negedge clk) m_arm_prev = m_arm;
    function automatic logic m_arm_q_for_req();
        return m_arm_prev && m_gie && msien;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        rd_t r;
        chk("cfg_interrupt_n", 32'(cfg_interrupt_n), 32'(!m_req));
        chk("irq_pending", 32'(irq_pending), 32'(|(m_stat & m_mask)));
        chk("gpio_out", 32'(gpio_out), 32'(m_dout));
        chk("gpio_oe", 32'(gpio_oe), 32'(m_dir));
        if (reg_rvalid) begin
            if (rdq.size() == 0) begin
                chk("rvalid_unexpected", 32'(reg_rvalid), 32'd0);
            end else begin
                r = rdq.pop_front();
                chk("rvalid_cycle", cyc, r.due);
                chk("rdata", reg_rdata, r.data);
                m_last = r.data;
            end
        end else begin
            chk("rdata_hold", reg_rdata, m_last);
            if (rdq.size() > 0 && rdq[0].due <= cyc) begin
                chk("rvalid_missing", 32'(reg_rvalid), 32'd1);
                void'(rdq.pop_front());
            end
        end
    end

    // MSI acknowledge driver, settles after the stimulus at each negedge
    always @(negedge clk) begin
        #2;
        rdy_n = !(!cfg_interrupt_n &&
                  (force_ack || (auto_ack && $urandom_range(0, 2) == 0)));
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        @(negedge clk);
        reg_wr = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        reg_rd = 1'b1; reg_addr = a;
        @(negedge clk);
        reg_rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (cfg_interrupt_n && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(cfg_interrupt_n), 32'd0);
    endtask

    task automatic ack_req();
        int n = 0;
        force_ack = 1'b1;
        while (!cfg_interrupt_n && n < 20) begin
            @(negedge clk);
            n++;
        end
        force_ack = 1'b0;
        chk("ack_release", 32'(cfg_interrupt_n), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [31:0] d;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // 1: outputs and basic read latency
        wr(3'd2, 32'hFF);
        wr(3'd1, 32'hA5);
        chk("gpio_oe_t1", 32'(gpio_oe), 32'hFF);
        chk("gpio_out_t1", 32'(gpio_out), 32'hA5);
        rd(3'd1);
        idle(1);
        chk("read_dout", reg_rdata, 32'hA5);

        // 2: rising edge to MSI latency
        wr(3'd4, 32'h01);
        wr(3'd3, 32'h01);
        wr(3'd7, 32'h1);
        msien = 1'b1;
        idle(3);
        gpio_in[0] = 1'b1;
        n = 0;
        while (cfg_interrupt_n && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("msi_latency", n, S + 2);
        idle(4);
        chk("msi_held", 32'(cfg_interrupt_n), 32'd0);
        ack_req();
        rd(3'd6);
        idle(3);

        // 3: unmasked capture, no MSI, W1C
        wr(3'd6, 32'h01);
        wr(3'd5, 32'h02);
        wr(3'd3, 32'h00);
        gpio_in[1] = 1'b1;
        idle(5);
        gpio_in[1] = 1'b0;
        idle(6);
        chk("no_msi", 32'(cfg_interrupt_n), 32'd1);
        rd(3'd6);
        idle(1);
        chk("status_fall", reg_rdata, 32'h02);
        wr(3'd6, 32'h02);
        rd(3'd6);
        idle(1);
        chk("status_w1c", reg_rdata, 32'h00);

        // 4: holdoff coalescing
        wr(3'd3, 32'h01);
        wr(3'd7, (32'd100 << 16) | 32'd1);
        gpio_in[0] = 1'b0;
        idle(5);
        gpio_in[0] = 1'b1;
        wait_req("msi_first");
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        fork
            begin
                n = 0;
                while (cfg_interrupt_n && n < 300) begin
                    @(negedge clk);
                    n++;
                end
            end
            begin
                repeat (3) begin
                    idle(5);
                    gpio_in[0] = 1'b0;
                    idle(5);
                    gpio_in[0] = 1'b1;
                end
            end
        join
        chk("holdoff_gap", n, 100 + 2);
        ack_req();
        idle(150);
        chk("coalesced", 32'(cfg_interrupt_n), 32'd1);
        wr(3'd7, 32'h1);
        idle(3);

        // 5a: W1C and capture on the same bit in the same cycle
        auto_ack = 1'b1;
        gpio_in[0] = 1'b0;
        idle(6);
        gpio_in[0] = 1'b1;
        idle(S);
        wr(3'd6, 32'h01);
        rd(3'd6);
        idle(1);
        chk("w1c_set_wins", 32'(reg_rdata[0]), 32'd1);
        idle(10);
        auto_ack = 1'b0;
        idle(5);

        // 5b: dropping msienable withdraws the request
        gpio_in[0] = 1'b0;
        idle(5);
        gpio_in[0] = 1'b1;
        wait_req("msi_5b");
        msien = 1'b0;
        idle(2);
        chk("msien_drop", 32'(cfg_interrupt_n), 32'd1);
        msien = 1'b1;
        idle(3);
        chk("msien_restore", 32'(cfg_interrupt_n), 32'd0);
        ack_req();
        idle(3);

        // 6: reset in the middle of a request
        gpio_in[0] = 1'b0;
        idle(5);
        gpio_in[0] = 1'b1;
        wait_req("msi_6");
        gpio_in = '0;
        idle(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async", 32'(cfg_interrupt_n), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            idle(1);
            chk("reset_reg", reg_rdata, 32'd0);
        end

        // randomized traffic
        msien = 1'b1;
        auto_ack = 1'b1;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    d = $urandom;
                    reg_addr = 3'($urandom_range(0, 7));
                    if (reg_addr == 3'd7)
                        d[31:16] = 16'($urandom_range(0, 15));
                    wr(reg_addr, d);
                end
                3, 4: rd(3'($urandom_range(0, 7)));
                5, 6: begin
                    gpio_in = gpio_in ^ N'($urandom);
                    idle(1);
                end
                7: begin
                    if ($urandom_range(0, 9) == 0) msien = ~msien;
                    idle(1);
                end
                default: idle(1);
            endcase
        end
        msien = 1'b1;
        idle(40);
        chk("read_drain", rdq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
